// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetch-stage control for the 5-stage pipeline.
// Drives PC load/enable and keeps at most one instruction-memory request in
// flight. It holds a one-entry instruction buffer in front of decode, applies
// EX redirects and throws away responses that a redirect has made stale.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN.
//   Defined:   a redirect to a non-word-aligned target raises a sticky
//              fetch_fault. Any outstanding response is drained and fetch then
//              halts until reset.
//   Undefined: redirect targets are forced to word alignment, fetch_fault is 0
//              and the halt state is never entered.
module fetch_sequencer #(
  parameter int addr_width  = 32,
  parameter int instr_width = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [addr_width-1:0]  pc_state,
  output logic                   pc_load,
  output logic [addr_width-1:0]  pc_load_val,
  output logic                   pc_enable,
  output logic                   imem_req_valid,
  output logic [addr_width-1:0]  imem_req_addr,
  input  logic                   imem_req_ready,
  input  logic                   imem_rsp_valid,
  input  logic [instr_width-1:0] imem_rsp_data,
  input  logic                   redirect_valid,
  input  logic [addr_width-1:0]  redirect_pc,
  output logic                   if_valid,
  output logic [instr_width-1:0] if_instr,
  output logic [addr_width-1:0]  if_pc,
  input  logic                   if_ready,
  output logic                   fetch_fault
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_DRAIN = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  localparam logic [addr_width-1:0] WORD_MASK = ~addr_width'(3);

  state_t                 state_q, state_d;
  logic                   buf_vld_q, buf_vld_d;
  logic [instr_width-1:0] buf_instr_q, buf_instr_d;
  logic [addr_width-1:0]  buf_pc_q, buf_pc_d;
  logic [addr_width-1:0]  tag_q, tag_d;
  logic                   fault_q, fault_d;

  logic redir_act;   // redirect seen in a state that honours it
  logic redir_bad;   // honoured redirect with a misaligned target
  logic redir_ok;    // honoured redirect that reloads the PC
  logic consume;     // decode takes the buffered entry this cycle
  logic req_fire;    // request handshake completes this cycle

  // Clear the byte-offset bits of an address.
  function automatic logic [addr_width-1:0] word_align(input logic [addr_width-1:0] a);
    return a & WORD_MASK;
  endfunction

`ifdef FETCH_MISALIGN_CHECK_EN
  // True when an address is not on a 4-byte boundary.
  function automatic logic is_misaligned(input logic [addr_width-1:0] a);
    return (a & ~WORD_MASK) != '0;
  endfunction
`endif

  // Classify the redirect input against the current state.
  always_comb begin
    redir_act = redirect_valid && (state_q != S_IDLE) && (state_q != S_HALT);
`ifdef FETCH_MISALIGN_CHECK_EN
    redir_bad = redir_act && is_misaligned(redirect_pc);
`else
    redir_bad = 1'b0;
`endif
    redir_ok  = redir_act && !redir_bad;
  end

  // Handshake and interface outputs; a request goes out only when the buffer
  // is guaranteed free by the time its response can arrive.
  always_comb begin
    consume        = buf_vld_q && if_ready;
    imem_req_addr  = pc_state;
    imem_req_valid = (state_q == S_REQ) && (!buf_vld_q || consume);
    req_fire       = imem_req_valid && imem_req_ready;
    pc_enable      = req_fire && !redir_act;
    pc_load        = redir_ok;
    pc_load_val    = redir_ok ? word_align(redirect_pc) : '0;
    if_valid       = buf_vld_q;
    if_instr       = buf_vld_q ? buf_instr_q : '0;
    if_pc          = buf_vld_q ? buf_pc_q : '0;
    fetch_fault    = fault_q;
  end

  // Next-state, buffer fill/flush and request tag capture.
  always_comb begin
    state_d     = state_q;
    tag_d       = tag_q;
    fault_d     = fault_q || redir_bad;
    buf_vld_d   = buf_vld_q && !consume;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;

    unique case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
      end
      S_REQ: begin
        if (req_fire) begin
          // A request accepted together with a redirect fetches the wrong
          // address, so its response must be drained.
          tag_d   = pc_state;
          state_d = redir_act ? S_DRAIN : S_WAIT;
        end else if (redir_bad) begin
          state_d = S_HALT;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          if (!redir_act) begin
            buf_vld_d   = 1'b1;
            buf_instr_d = imem_rsp_data;
            buf_pc_d    = tag_q;
            state_d     = S_REQ;
          end else begin
            state_d = redir_bad ? S_HALT : S_REQ;
          end
        end else if (redir_act) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (imem_rsp_valid) begin
          state_d = (fault_q || redir_bad) ? S_HALT : S_REQ;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Any honoured redirect empties the buffer, whether or not decode is ready.
    if (redir_act) begin
      buf_vld_d = 1'b0;
    end
  end

  // Control state: FSM, buffer occupancy and the sticky fault flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      buf_vld_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      buf_vld_q <= buf_vld_d;
      fault_q   <= fault_d;
    end
  end

  // Buffer payload and request tag; these are only observed while valid.
  always_ff @(posedge clk) begin
    buf_instr_q <= buf_instr_d;
    buf_pc_q    <= buf_pc_d;
    tag_q       <= tag_d;
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: randomized scoreboard bench for fetch_sequencer.
// The bench models a PC register and an instruction memory. The reference
// model tracks the architectural fetch stream: sequential word addresses,
// restarted at every redirect target.
module tb_fetch_sequencer;
  localparam int AW = 32;
  localparam int IW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] pc_state = '0;
  logic          pc_load, pc_enable, imem_req_valid, if_valid, fetch_fault;
  logic [AW-1:0] pc_load_val, imem_req_addr, if_pc;
  logic [IW-1:0] if_instr;
  logic          imem_req_ready = 1'b0, imem_rsp_valid = 1'b0;
  logic [IW-1:0] imem_rsp_data = '0;
  logic          redirect_valid = 1'b0, if_ready = 1'b0;
  logic [AW-1:0] redirect_pc = '0;

  fetch_sequencer #(.addr_width(AW), .instr_width(IW)) dut (
    .clk(clk), .reset(reset), .pc_state(pc_state),
    .pc_load(pc_load), .pc_load_val(pc_load_val), .pc_enable(pc_enable),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .if_valid(if_valid), .if_instr(if_instr),
    .if_pc(if_pc), .if_ready(if_ready), .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [AW-1:0] pc; logic [IW-1:0] instr; } ent_t;
  ent_t exp_q[$];
  int total = 0, bad = 0;

  // knobs
  int p_ready = 100, p_ifr = 100, p_redir = 0, lat_min = 1, lat_max = 1;
  // imem responder state
  bit outst = 0, stale = 0;
  int cnt = 0;
  logic [AW-1:0] outst_addr = '0;
  // reference model / bookkeeping
  logic [AW-1:0] exp_addr = '0, hold_pc = '0, last_pop_pc = '0;
  logic [IW-1:0] hold_instr = '0;
  bit expect_vld = 0, flush_chk = 0, hold_chk = 0, halted = 0, fault_exp = 0;
  int cyc = 0, pops = 0;
  logic [AW-1:0] acc_addr[$];
  int acc_cyc[$], pop_cyc[$];
  bit acc_redir[$];

  function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // PC register model
  always @(posedge clk) begin
    if (reset) pc_state <= '0;
    else if (pc_load) pc_state <= pc_load_val;
    else if (pc_enable) pc_state <= pc_state + 4;
  end

  // Stimulus: drive one cycle, return after that cycle's bookkeeping.
  task automatic step(input bit redir, input logic [AW-1:0] tgt);
    @(posedge clk); #1;
    imem_req_ready = ($urandom_range(99) < p_ready);
    if_ready       = ($urandom_range(99) < p_ifr);
    redirect_valid = redir;
    redirect_pc    = tgt;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    if (outst) begin
      cnt--;
      if (cnt <= 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(outst_addr);
      end
    end
    @(negedge clk); #2;
  endtask

  function automatic logic [AW-1:0] rand_tgt();
    logic [AW-1:0] t;
`ifdef FETCH_MISALIGN_CHECK_EN
    t = AW'($urandom_range(1023)) << 2;
`else
    t = AW'($urandom_range(4095));
`endif
    return t;
  endfunction

  task automatic rand_step();
    bit r;
    r = (cyc >= 1) && ($urandom_range(99) < p_redir);
    step(r, rand_tgt());
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      reset = 1'b1; redirect_valid = 1'b0; imem_rsp_valid = 1'b0;
      imem_req_ready = 1'b1; if_ready = 1'b1;
      @(negedge clk); #2;
      if (i >= 1) begin
        chk("rst_pc_load", pc_load, 0);
        chk("rst_pc_load_val", pc_load_val, 0);
        chk("rst_pc_enable", pc_enable, 0);
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_if_valid", if_valid, 0);
        chk("rst_if_instr", if_instr, 0);
        chk("rst_if_pc", if_pc, 0);
        chk("rst_fetch_fault", fetch_fault, 0);
      end
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk); #2;
  endtask

  task automatic expect_next_accept(input string nm, input logic [AW-1:0] addr);
    int n;
    bit seen;
    n = acc_addr.size();
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step(1'b0, '0);
      if (acc_addr.size() > n) seen = 1;
    end
    if (seen) chk(nm, acc_addr[n], addr);
    else begin total++; bad++; $display("FAIL %s actual=no request required=%0h", nm, addr); end
  endtask

  task automatic expect_next_pop(input string nm, input logic [AW-1:0] addr);
    int n;
    bit seen;
    n = pops;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (pops > n) seen = 1;
      else step(1'b0, '0);
    end
    if (!seen && pops > n) seen = 1;
    if (seen) chk(nm, last_pop_pc, addr);
    else begin total++; bad++; $display("FAIL %s actual=no delivery required=%0h", nm, addr); end
  endtask

  task automatic wait_accept(input string nm);
    int n;
    bit seen;
    n = acc_addr.size();
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step(1'b0, '0);
      if (acc_addr.size() > n) seen = 1;
    end
    if (!seen) begin total++; bad++; $display("FAIL %s actual=no request required=request", nm); end
  endtask

  // Environment bookkeeping: handshakes, reference model updates, protocol checks.
  always @(negedge clk) begin : bk
    bit had, mis;
    #1;
    if (reset) begin
      exp_q.delete();
      outst = 0; stale = 0; cnt = 0; exp_addr = '0;
      expect_vld = 0; flush_chk = 0; hold_chk = 0; halted = 0; fault_exp = 0; cyc = 0;
    end else begin
      cyc++;
      had = outst;
      chk("load_enable_exclusive", pc_load & pc_enable, 0);
      if (imem_req_valid) chk("req_addr", imem_req_addr, pc_state);
      if (if_valid && !if_ready) chk("req_while_buffer_full", imem_req_valid, 0);
      if (halted) chk("req_after_halt", imem_req_valid, 0);
`ifdef FETCH_MISALIGN_CHECK_EN
      chk("fetch_fault", fetch_fault, fault_exp);
`else
      chk("fetch_fault", fetch_fault, 0);
`endif
      if (imem_rsp_valid) begin
        if (!stale && !redirect_valid) begin
          exp_q.push_back('{pc: exp_addr, instr: mem_word(exp_addr)});
          exp_addr += 4;
          expect_vld = 1;
        end
        outst = 0; stale = 0;
      end
      if (imem_req_valid && imem_req_ready) begin
        chk("one_outstanding", had, 0);
        chk("pc_enable_on_accept", pc_enable, !redirect_valid);
        outst = 1; stale = redirect_valid; outst_addr = imem_req_addr;
        cnt = $urandom_range(lat_max, lat_min);
        acc_addr.push_back(imem_req_addr); acc_cyc.push_back(cyc); acc_redir.push_back(redirect_valid);
      end else begin
        chk("pc_enable_no_accept", pc_enable, 0);
      end
      if (redirect_valid && !halted) begin
        mis = 0;
`ifdef FETCH_MISALIGN_CHECK_EN
        mis = (redirect_pc[1:0] != 2'b00);
`endif
        exp_q.delete();
        flush_chk = 1; hold_chk = 0;
        if (outst) stale = 1;
        if (mis) begin
          chk("no_load_on_misaligned", pc_load, 0);
          halted = 1; fault_exp = 1;
        end else begin
          chk("pc_load", pc_load, 1);
          chk("pc_load_val", pc_load_val, {redirect_pc[AW-1:2], 2'b00});
          exp_addr = {redirect_pc[AW-1:2], 2'b00};
        end
      end else if (!redirect_valid) begin
        chk("pc_load_quiet", pc_load, 0);
      end
      if (if_valid && !if_ready && !redirect_valid) begin
        hold_chk = 1; hold_pc = if_pc; hold_instr = if_instr;
      end
    end
  end

  // Scoreboard monitor: pops an expected entry whenever decode consumes one.
  always @(negedge clk) begin : mon
    ent_t e;
    if (!reset) begin
      if (expect_vld) begin chk("rsp_to_if_valid", if_valid, 1); expect_vld = 0; end
      if (flush_chk) begin chk("flush_on_redirect", if_valid, 0); flush_chk = 0; end
      if (hold_chk) begin
        chk("hold_valid", if_valid, 1);
        chk("hold_pc", if_pc, hold_pc);
        chk("hold_instr", if_instr, hold_instr);
        hold_chk = 0;
      end
      if (if_valid) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL spurious_if_valid actual if_pc=%0h required=no entry", if_pc);
        end else if (if_ready) begin
          e = exp_q.pop_front();
          chk("if_pc", if_pc, e.pc);
          chk("if_instr", if_instr, e.instr);
          pops++; last_pop_pc = if_pc; pop_cyc.push_back(cyc);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    do_reset(3);

    // Straight-line fetch, 1-cycle memory, decode always ready.
    p_ready = 100; p_ifr = 100; p_redir = 0; lat_min = 1; lat_max = 1;
    for (int i = 0; i < 9; i++) step(1'b0, '0);
    if (acc_addr.size() >= 3 && pop_cyc.size() >= 3) begin
      chk("t1_first_req_cycle", acc_cyc[0], 2);
      chk("t1_req0", acc_addr[0], 32'h0);
      chk("t1_req1", acc_addr[1], 32'h4);
      chk("t1_req2", acc_addr[2], 32'h8);
      chk("t1_req_gap", acc_cyc[1] - acc_cyc[0], 2);
      chk("t1_if_gap1", pop_cyc[1] - pop_cyc[0], 2);
      chk("t1_if_gap2", pop_cyc[2] - pop_cyc[1], 2);
    end else begin
      total++; bad++;
      $display("FAIL t1_count actual=%0d required=3", pop_cyc.size());
    end

    // Decode stalls with a full buffer, then releases.
    p_ifr = 0;
    for (int i = 0; i < 6; i++) step(1'b0, '0);
    chk("t2_full", if_valid, 1);
    chk("t2_no_req", imem_req_valid, 0);
    p_ifr = 100;
    step(1'b0, '0);
    chk("t2_req_on_release", imem_req_valid, 1);

    // Redirect while waiting on a slow response.
    lat_min = 3; lat_max = 3;
    wait_accept("t3_wait_accept");
    step(1'b1, 32'h100);
    chk("t3_pc_load", pc_load, 1);
    chk("t3_pc_load_val", pc_load_val, 32'h100);
    expect_next_accept("t3_next_req", 32'h100);
    expect_next_pop("t3_next_if_pc", 32'h100);

    // Redirect in the same cycle as the response.
    lat_min = 2; lat_max = 2;
    wait_accept("t4_wait_accept");
    while (outst && cnt > 1) step(1'b0, '0);
    step(1'b1, 32'h200);
    chk("t4_rsp_seen", imem_rsp_valid, 1);
    expect_next_accept("t4_next_req", 32'h200);
    expect_next_pop("t4_next_if_pc", 32'h200);

    // Redirect in the same cycle as a request accept.
    lat_min = 1; lat_max = 1;
    wait_accept("t5_wait_accept");
    step(1'b0, '0);
    step(1'b1, 32'h300);
    chk("t5_accept_with_redirect", acc_redir[$], 1);
    chk("t5_pc_enable", pc_enable, 0);
    expect_next_accept("t5_next_req", 32'h300);
    expect_next_pop("t5_next_if_pc", 32'h300);

    // Randomized traffic, then a mid-run reset and more traffic.
    p_ready = 70; p_ifr = 65; p_redir = 8; lat_min = 1; lat_max = 3;
    for (int i = 0; i < 3000; i++) rand_step();
    do_reset(3);
    for (int i = 0; i < 1000; i++) rand_step();
    chk("progress", pops > 300, 1);

    // Misaligned redirect.
    p_ready = 100; p_ifr = 100; p_redir = 0; lat_min = 2; lat_max = 2;
    for (int i = 0; i < 4; i++) step(1'b0, '0);
    step(1'b1, 32'h102);
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("t6_no_load", pc_load, 0);
    n = acc_addr.size();
    for (int i = 0; i < 12; i++) step(1'b0, '0);
    chk("t6_fault", fetch_fault, 1);
    chk("t6_no_more_reqs", acc_addr.size() - n, 0);
`else
    chk("t6_pc_load_val", pc_load_val, 32'h100);
    step(1'b0, '0);
    chk("t6_no_fault", fetch_fault, 0);
    expect_next_accept("t6_next_req", 32'h100);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
